// File: rtl/post_normalization_seq.sv
// rtl/post_normalization_seq.sv - FPU add/sub post-normalization, RNE rounding and IEEE-754 single packing
module post_normalization_seq #(
  parameter int FORMAT_LENGTH   = 32,
  parameter int EXPONENT_LENGTH = 8,
  parameter int FRACTION_LENGTH = 23,
  parameter int MAN_IN_LENGTH   = 28
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       enable,
  input  logic [FORMAT_LENGTH-1:0]   special_result,
  input  logic [EXPONENT_LENGTH-1:0] exp,
  input  logic [MAN_IN_LENGTH-1:0]   man_sum,
  input  logic                       sign,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FORMAT_LENGTH-1:0]   result,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       inexact
);
  localparam int CAR = MAN_IN_LENGTH - 1;
  localparam int HID = MAN_IN_LENGTH - 2;
  localparam int EW  = EXPONENT_LENGTH;
  localparam int FW  = FRACTION_LENGTH;
  localparam logic [EW:0] EXP_ONE = (EW+1)'(1);
  localparam logic [EW:0] EXP_INF = {1'b0, {EW{1'b1}}};

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t                   r_state, w_next;
  logic                     r_alive;
  logic [MAN_IN_LENGTH-1:0] r_man;
  logic [EW:0]              r_exp;
  logic                     r_sign;
  logic [FORMAT_LENGTH-1:0] r_result;
  logic                     r_overflow, r_underflow, r_inexact;

  logic                     w_accept, w_zero;
  logic [MAN_IN_LENGTH-1:0] w_src_man, w_step_man;
  logic [EW:0]              w_src_exp, w_step_exp;
  logic                     w_step_done;
  logic                     w_up, w_rhid, w_rovf;
  logic [FW+1:0]            w_rsum;
  logic [EW:0]              w_rexp;
  logic [FW-1:0]            w_rfrac;
  logic [EW-1:0]            w_field;

  assign w_accept = in_valid & in_ready;
  assign w_zero   = (man_sum == '0);

  // One normalization step; the accepting edge already applies it to the raw inputs.
  always_comb begin
    w_src_man   = (r_state == IDLE) ? man_sum : r_man;
    w_src_exp   = (r_state == IDLE) ? {1'b0, exp} : r_exp;
    w_step_man  = w_src_man;
    w_step_exp  = w_src_exp;
    w_step_done = 1'b1;
    if (w_src_man[CAR]) begin
      w_step_man = {1'b0, w_src_man[CAR:2], w_src_man[1] | w_src_man[0]};
      w_step_exp = w_src_exp + EXP_ONE;
    end else if (!w_src_man[HID] && (w_src_exp > EXP_ONE)) begin
      w_step_man  = {w_src_man[CAR-1:0], 1'b0};
      w_step_exp  = w_src_exp - EXP_ONE;
      w_step_done = 1'b0;
    end
  end

  always_comb begin
    w_up    = r_man[2] & (r_man[1] | r_man[0] | r_man[3]);
    w_rsum  = {1'b0, r_man[HID:3]} + {{(FW+1){1'b0}}, w_up};
    w_rexp  = r_exp + {{EW{1'b0}}, w_rsum[FW+1]};
    w_rhid  = w_rsum[FW+1] | w_rsum[FW];
    w_rfrac = w_rsum[FW+1] ? '0 : w_rsum[FW-1:0];
    w_rovf  = (w_rexp >= EXP_INF);
    w_field = w_rhid ? w_rexp[EW-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) begin
        if (!enable || w_zero) w_next = DONE;
        else if (w_step_done)  w_next = ROUND;
        else                   w_next = NORM;
      end
      NORM:    if (w_step_done) w_next = ROUND;
      ROUND:   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = r_alive && (r_state == IDLE);
    out_valid = (r_state == DONE);
    result    = r_result;
    overflow  = r_overflow;
    underflow = r_underflow;
    inexact   = r_inexact;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive     <= 1'b0;
      r_man       <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_inexact   <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      case (r_state)
        IDLE: if (w_accept) begin
          r_overflow  <= 1'b0;
          r_underflow <= 1'b0;
          r_inexact   <= 1'b0;
          r_sign      <= sign;
          r_man       <= w_step_man;
          r_exp       <= w_step_exp;
          if (!enable)     r_result <= special_result;
          else if (w_zero) r_result <= '0;
        end
        NORM: begin
          r_man <= w_step_man;
          r_exp <= w_step_exp;
        end
        ROUND: begin
          r_inexact <= |r_man[2:0];
          if (w_rovf) begin
            r_result   <= {r_sign, {EW{1'b1}}, {FW{1'b0}}};
            r_overflow <= 1'b1;
          end else begin
            r_result    <= {r_sign, w_field, w_rfrac};
            r_underflow <= (w_field == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_post_normalization_seq.sv
// tb/tb_post_normalization_seq.sv - randomized self-checking bench for post_normalization_seq
module tb_post_normalization_seq;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, enable, sign, out_valid, out_ready;
  logic        overflow, underflow, inexact;
  logic [31:0] special_result, result;
  logic [7:0]  exp;
  logic [27:0] man_sum;
  int          checks = 0;
  int          errors = 0;

  post_normalization_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .enable(enable), .special_result(special_result), .exp(exp), .man_sum(man_sum),
    .sign(sign), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  // Reference: locate leading one, shift, round the value m/8 to nearest-even integer.
  function automatic void ref_model(input logic en, input logic [31:0] sp, input logic [7:0] e,
                                    input logic [27:0] m, input logic s,
                                    output logic [31:0] res, output logic [2:0] flg, output int lat);
    longint mm, keep, rem;
    int ee, p, k;
    logic [7:0] fld;
    flg = 3'b000;
    if (!en) begin res = sp; lat = 1; return; end
    if (m == 28'd0) begin res = 32'h0; lat = 1; return; end
    mm = longint'(m); ee = int'(e); k = 0; p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    if (p == 27) begin
      mm = (mm >> 1) | (mm & 1);
      ee = ee + 1;
    end else begin
      k = 26 - p;
      if (k > ee - 1) k = ee - 1;
      mm = mm << k;
      ee = ee - k;
    end
    lat = 2 + k;
    keep = mm >> 3;
    rem  = mm & 7;
    flg[0] = (rem != 0);
    if (rem > 4 || (rem == 4 && (keep % 2) == 1)) keep = keep + 1;
    if (keep == 64'd16777216) begin keep = 64'd8388608; ee = ee + 1; end
    if (ee >= 255) begin
      res = {s, 8'hFF, 23'h0};
      flg[2] = 1'b1;
    end else begin
      fld = (keep >= 64'd8388608) ? 8'(ee) : 8'd0;
      flg[1] = (fld == 8'd0);
      res = {s, fld, 23'(keep)};
    end
  endfunction

  task automatic run_op(input logic en, input logic [31:0] sp, input logic [7:0] e,
                        input logic [27:0] m, input logic s, input int hold,
                        output logic [31:0] res, output logic [2:0] flg,
                        output int lat, output logic stable);
    int guard;
    @(negedge clk);
    enable = en; special_result = sp; exp = e; man_sum = m; sign = s;
    in_valid = 1'b1; out_ready = 1'b0;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    man_sum = 28'($urandom); exp = 8'($urandom); sign = 1'($urandom);
    enable = 1'($urandom); special_result = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin @(posedge clk); #1; lat++; end
    res = result; flg = {overflow, underflow, inexact}; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || result !== res || {overflow, underflow, inexact} !== flg ||
          in_ready !== 1'b0) stable = 1'b0;
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    if (out_valid !== 1'b0) stable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; enable = 1'b0;
    special_result = 32'h0; exp = 8'h0; man_sum = 28'h0; sign = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if ({overflow, underflow, inexact} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {overflow, underflow, inexact}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] vres [7];
    logic [2:0]  vflg [7];
    int          vlat [7];
    logic [7:0]  ve   [7];
    logic [27:0] vm   [7];
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    logic        st;
    ve[0] = 8'h7E; vm[0] = {1'b0, 1'b1, 23'h580000, 3'b0};  vres[0] = 32'h3F580000; vflg[0] = 3'b000; vlat[0] = 2;
    ve[1] = 8'h7E; vm[1] = {1'b0, 1'b0, 23'h280000, 3'b0};  vres[1] = 32'h3E200000; vflg[1] = 3'b000; vlat[1] = 4;
    ve[2] = 8'h7F; vm[2] = {2'b11, 23'h0, 3'b0};            vres[2] = 32'h40400000; vflg[2] = 3'b000; vlat[2] = 2;
    ve[3] = 8'hFE; vm[3] = {2'b10, 23'h0, 3'b0};            vres[3] = 32'h7F800000; vflg[3] = 3'b100; vlat[3] = 2;
    ve[4] = 8'h7F; vm[4] = {1'b0, 1'b1, 23'h7FFFFF, 3'b100}; vres[4] = 32'h40000000; vflg[4] = 3'b001; vlat[4] = 2;
    ve[5] = 8'h7F; vm[5] = 28'h0;                           vres[5] = 32'h00000000; vflg[5] = 3'b000; vlat[5] = 1;
    ve[6] = 8'h03; vm[6] = {2'b00, 1'b0, 23'h001000, 3'b0}; vres[6] = 32'h00004000; vflg[6] = 3'b010; vlat[6] = 4;
    for (int i = 0; i < 7; i++) begin
      run_op(1'b1, 32'h0, ve[i], vm[i], 1'b0, 1, res, flg, lat, st);
      checks++; if (res !== vres[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, res, vres[i]); end
      checks++; if (flg !== vflg[i]) begin errors++; $display("FAIL dir%0d_flags got %b want %b", i, flg, vflg[i]); end
      checks++; if (lat != vlat[i]) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, vlat[i]); end
    end
  endtask

  task automatic test_bypass_backpressure();
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    logic        st;
    run_op(1'b0, 32'h7FC00000, 8'h7F, 28'h4000000, 1'b1, 5, res, flg, lat, st);
    checks++; if (res !== 32'h7FC00000) begin errors++; $display("FAIL bypass_result got %h want 7fc00000", res); end
    checks++; if (flg !== 3'b000) begin errors++; $display("FAIL bypass_flags got %b want 000", flg); end
    checks++; if (lat != 1) begin errors++; $display("FAIL bypass_latency got %0d want 1", lat); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL bypass_hold_stable got %b want 1", st); end
  endtask

  task automatic test_random();
    logic [31:0] res, eres, sp, mask;
    logic [2:0]  flg, eflg;
    int          lat, elat, nb;
    logic        st, en, s;
    logic [7:0]  e;
    logic [27:0] m;
    for (int n = 0; n < 300; n++) begin
      en = (($urandom % 8) != 0);
      sp = $urandom;
      s  = 1'($urandom);
      case ($urandom % 4)
        0:       e = 8'($urandom_range(1, 4));
        1:       e = 8'($urandom_range(250, 254));
        default: e = 8'($urandom_range(1, 254));
      endcase
      nb   = $urandom_range(0, 28);
      mask = (nb == 0) ? 32'h0 : ((32'h1 << nb) - 32'h1);
      m    = 28'($urandom & mask);
      if (($urandom % 4) == 0) m[2:0] = 3'b100;
      ref_model(en, sp, e, m, s, eres, eflg, elat);
      run_op(en, sp, e, m, s, $urandom_range(0, 3), res, flg, lat, st);
      checks++; if (res !== eres) begin errors++;
        $display("FAIL rand%0d_result got %h want %h (e=%h m=%h en=%b)", n, res, eres, e, m, en); end
      checks++; if (flg !== eflg) begin errors++; $display("FAIL rand%0d_flags got %b want %b", n, flg, eflg); end
      checks++; if (lat != elat) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", n, lat, elat); end
      checks++; if (st !== 1'b1) begin errors++; $display("FAIL rand%0d_handshake got %b want 1", n, st); end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    logic        st;
    @(negedge clk);
    enable = 1'b1; exp = 8'd200; man_sum = 28'h1; sign = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
    repeat (2) @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_held_out_valid got %b want 0", out_valid); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_release_out_valid got %b want 0", out_valid); end
    run_op(1'b1, 32'h0, 8'h7E, {1'b0, 1'b1, 23'h580000, 3'b0}, 1'b1, 0, res, flg, lat, st);
    checks++; if (res !== 32'hBF580000) begin errors++; $display("FAIL midrst_recover_result got %h want bf580000", res); end
    checks++; if (lat != 2) begin errors++; $display("FAIL midrst_recover_latency got %0d want 2", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_bypass_backpressure();
    test_random();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
